// File: rtl/seg_pkg.sv
// Shared segment definitions for the multiplexed 7-segment scan driver.
// All codes are active-high; bit 6 = g ... bit 0 = a.
package seg_pkg;

  typedef logic [6:0] seg_t;

  // Bit order of seg_t, most significant first.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  localparam seg_t SEG_CODE_0 = 7'h3F;
  localparam seg_t SEG_CODE_1 = 7'h06;
  localparam seg_t SEG_CODE_2 = 7'h5B;
  localparam seg_t SEG_CODE_3 = 7'h4F;
  localparam seg_t SEG_CODE_4 = 7'h66;
  localparam seg_t SEG_CODE_5 = 7'h6D;
  localparam seg_t SEG_CODE_6 = 7'h7D;
  localparam seg_t SEG_CODE_7 = 7'h07;
  localparam seg_t SEG_CODE_8 = 7'h7F;
  localparam seg_t SEG_CODE_9 = 7'h6F;
  localparam seg_t SEG_DASH   = 7'h40;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host-side bundle of the scan driver: display content in, pins and frame pulse out.
interface seg_scan_driver_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6
);

  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits_bcd;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blank_lz;
  seg_t                    seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output enable, digits_bcd, dp_mask, blink_mask, blank_lz,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  enable, digits_bcd, dp_mask, blink_mask, blank_lz,
    output seg, dp, an, frame_done
  );

endinterface

// File: rtl/seg_bcd_decode.sv
// Nibble to active-high segment pattern; non-BCD nibbles show a dash.
module seg_bcd_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_nibble)
      4'd0:    o_seg = SEG_CODE_0;
      4'd1:    o_seg = SEG_CODE_1;
      4'd2:    o_seg = SEG_CODE_2;
      4'd3:    o_seg = SEG_CODE_3;
      4'd4:    o_seg = SEG_CODE_4;
      4'd5:    o_seg = SEG_CODE_5;
      4'd6:    o_seg = SEG_CODE_6;
      4'd7:    o_seg = SEG_CODE_7;
      4'd8:    o_seg = SEG_CODE_8;
      4'd9:    o_seg = SEG_CODE_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment driver: per-digit slots with dead time, frame snapshot,
// leading-zero blanking, per-digit blink and registered pin outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int REFRESH_DIV    = 100000,
  parameter int DEAD_CYCLES    = 2,
  parameter int BLINK_DIV      = 25000000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic         clk,
  input logic         reset,
  seg_scan_driver_if.slave bus
);

  localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]  SLOT_DEAD  = SLOT_W'(DEAD_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic               SEG_INV    = (SEG_ACTIVE_LOW != 0);
  localparam logic               AN_INV     = (AN_ACTIVE_LOW != 0);

  logic [SLOT_W-1:0]       r_slot_cnt;
  logic [IDX_W-1:0]        r_digit_idx;
  logic [BLINK_W-1:0]      r_blink_cnt;
  logic                    r_blink_phase;
  logic [4*NUM_DIGITS-1:0] r_snap_bcd;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic [NUM_DIGITS-1:0]   r_snap_blink;
  logic                    r_snap_lz;
  logic                    r_frame_done;
  seg_t                    r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_slot_term;
  logic                    w_frame_wrap;
  logic                    w_blink_term;
  logic                    w_dead;
  logic [NUM_DIGITS-1:0]   w_lz_blank;
  logic                    w_lz_run;
  logic [3:0]              w_cur_nib;
  logic                    w_cur_dp;
  logic                    w_cur_blink;
  logic                    w_cur_lz;
  logic [NUM_DIGITS-1:0]   w_an_ah;
  seg_t                    w_cur_seg;
  logic                    w_digit_dark;
  seg_t                    w_seg_ah;
  logic                    w_dp_ah;

  assign w_slot_term  = (r_slot_cnt == SLOT_LAST);
  assign w_frame_wrap = w_slot_term && (r_digit_idx == IDX_LAST);
  assign w_blink_term = (r_blink_cnt == BLINK_LAST);
  assign w_dead       = (r_slot_cnt < SLOT_DEAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_cnt    <= '0;
      r_digit_idx   <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_snap_bcd    <= '0;
      r_snap_dp     <= '0;
      r_snap_blink  <= '0;
      r_snap_lz     <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_slot_cnt   <= w_slot_term ? '0 : r_slot_cnt + 1'b1;
      r_blink_cnt  <= w_blink_term ? '0 : r_blink_cnt + 1'b1;
      r_frame_done <= w_frame_wrap;
      if (w_slot_term) begin
        r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
      end
      if (w_blink_term) begin
        r_blink_phase <= ~r_blink_phase;
      end
      // Content is frozen per frame so a digit never changes mid-scan.
      if (w_frame_wrap) begin
        r_snap_bcd   <= bus.digits_bcd;
        r_snap_dp    <= bus.dp_mask;
        r_snap_blink <= bus.blink_mask;
        r_snap_lz    <= bus.blank_lz;
      end
    end
  end

  // Walk down from the most significant digit; the first nonzero (or dash) digit ends blanking.
  always_comb begin
    w_lz_blank = '0;
    w_lz_run   = r_snap_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (w_lz_run && (r_snap_bcd[4*k +: 4] == 4'd0)) begin
        w_lz_blank[k] = 1'b1;
      end else begin
        w_lz_run = 1'b0;
      end
    end
  end

  always_comb begin
    w_cur_nib   = '0;
    w_cur_dp    = 1'b0;
    w_cur_blink = 1'b0;
    w_cur_lz    = 1'b0;
    w_an_ah     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_digit_idx == IDX_W'(k)) begin
        w_cur_nib   = r_snap_bcd[4*k +: 4];
        w_cur_dp    = r_snap_dp[k];
        w_cur_blink = r_snap_blink[k];
        w_cur_lz    = w_lz_blank[k];
        w_an_ah[k]  = 1'b1;
      end
    end
  end

  seg_bcd_decode u_decode (
    .i_nibble (w_cur_nib),
    .o_seg    (w_cur_seg)
  );

  assign w_digit_dark = w_cur_lz | (w_cur_blink & r_blink_phase);
  assign w_seg_ah     = w_digit_dark ? '0 : w_cur_seg;
  assign w_dp_ah      = ~w_digit_dark & w_cur_dp;

  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      r_an  <= {NUM_DIGITS{AN_INV}};
      r_seg <= {7{SEG_INV}};
      r_dp  <= SEG_INV;
    end else begin
      r_an  <= (w_dead ? '0 : w_an_ah) ^ {NUM_DIGITS{AN_INV}};
      r_seg <= w_seg_ah ^ {7{SEG_INV}};
      r_dp  <= w_dp_ah ^ SEG_INV;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 4-cycle slots, 1 dead cycle, 32-cycle blink.
module tb_seg_scan_driver;

  // Active-low segment pins {g..a}
  localparam logic [6:0] L0 = 7'b1000000;
  localparam logic [6:0] L1 = 7'b1111001;
  localparam logic [6:0] L2 = 7'b0100100;
  localparam logic [6:0] L3 = 7'b0110000;
  localparam logic [6:0] L4 = 7'b0011001;
  localparam logic [6:0] L5 = 7'b0010010;
  localparam logic [6:0] L6 = 7'b0000010;
  localparam logic [6:0] L7 = 7'b1111000;
  localparam logic [6:0] L8 = 7'b0000000;
  localparam logic [6:0] LD = 7'b0111111;
  localparam logic [6:0] LX = 7'b1111111;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS     (4),
    .REFRESH_DIV    (4),
    .DEAD_CYCLES    (1),
    .BLINK_DIV      (32),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called where the next sample shows slot 0 of digit 0; walks the whole frame.
  task automatic check_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpl);
    logic [6:0] s [4];
    logic [3:0] an_e;
    logic       fd;
    s[0] = s0;
    s[1] = s1;
    s[2] = s2;
    s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        fd   = (d == 3) && (k == 3);
        an_e = ~(4'b0001 << d);
        if (k == 0)
          chk($sformatf("%s_d%0d_dead", tag, d), 13'({bus.an, bus.frame_done}), 13'({4'hF, fd}));
        else
          chk($sformatf("%s_d%0d_s%0d", tag, d, k),
              {bus.an, bus.seg, bus.dp, bus.frame_done}, {an_e, s[d], dpl[d], fd});
      end
    end
  endtask

  task automatic next_frame();
    int n;
    n = 0;
    step();
    while (bus.frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("next_frame_seen", 13'(bus.frame_done), 13'(1'b1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.enable      = 1'b1;
    bus.digits_bcd  = 16'h1234;
    bus.dp_mask     = 4'b0000;
    bus.blink_mask  = 4'b0000;
    bus.blank_lz    = 1'b0;
    repeat (3) step();
    chk("reset_dark", {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hF, LX, 1'b1, 1'b0});
    reset = 1'b0;

    // Frame 0 shows the cleared snapshot; frame 1 the captured 1234.
    check_frame("f0_zero", L0, L0, L0, L0, 4'hF);
    check_frame("f1_1234", L1, L2, L3, L4, 4'hF);

    bus.digits_bcd = 16'h5678;
    check_frame("f2_old", L1, L2, L3, L4, 4'hF);
    check_frame("f3_new", L5, L6, L7, L8, 4'hF);

    bus.digits_bcd = 16'h0007;
    bus.blank_lz   = 1'b1;
    next_frame();
    check_frame("lz_on", LX, LX, LX, L7, 4'hF);

    bus.blank_lz = 1'b0;
    next_frame();
    check_frame("lz_off", L0, L0, L0, L7, 4'hF);

    // Frames 9..12 cover cycles 144..207: blink phase 0,1,1,0.
    bus.digits_bcd = 16'h1234;
    bus.blink_mask = 4'b0011;
    next_frame();
    check_frame("blink_lit_a", L1, L2, L3, L4, 4'hF);
    check_frame("blink_dark_a", L1, L2, LX, LX, 4'hF);
    check_frame("blink_dark_b", L1, L2, LX, LX, 4'hF);
    check_frame("blink_lit_b", L1, L2, L3, L4, 4'hF);

    bus.blink_mask = 4'b0000;
    bus.digits_bcd = 16'h0B00;
    bus.blank_lz   = 1'b1;
    bus.dp_mask    = 4'b0100;
    next_frame();
    check_frame("dash_dp", LX, LD, L0, L0, 4'b1011);

    bus.enable = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("disabled_%0d", i), {bus.an, bus.seg, bus.dp, bus.frame_done},
          {4'hF, LX, 1'b1, (i == 16)});
    end
    bus.enable = 1'b1;
    check_frame("reenabled", LX, LD, L0, L0, 4'b1011);

    repeat (10) step();
    chk("pre_reset_d2", 13'({bus.an, bus.seg, bus.dp}), 13'({4'b1011, LD, 1'b0}));
    reset = 1'b1;
    step();
    chk("mid_reset_dark", {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hF, LX, 1'b1, 1'b0});
    reset = 1'b0;
    check_frame("restart", L0, L0, L0, L0, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 6, number of multiplexed digits, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot, SHALL exceed DEAD_CYCLES+1.
REQ-003 Parameter DEAD_CYCLES, default 2, all-anodes-off cycles at the start of each slot (anti-ghosting).
REQ-004 Parameter BLINK_DIV, default 25000000, clk cycles per blink half-period.
REQ-005 Parameter SEG_ACTIVE_LOW, default 1, 1 = segment/dp lit when driven 0.
REQ-006 Parameter AN_ACTIVE_LOW, default 1, 1 = digit enabled when anode driven 0.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 enable  in  1  0 = display dark; counters keep running.
REQ-010 digits_bcd  in  4*NUM_DIGITS  BCD nibbles, digit 0 (rightmost) in [3:0].
REQ-011 dp_mask  in  NUM_DIGITS  decimal point request per digit.
REQ-012 blink_mask  in  NUM_DIGITS  per-digit blink enable (time-setting mode).
REQ-013 blank_lz  in  1  leading-zero blanking enable.
REQ-014 seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
REQ-015 dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW.
REQ-016 an  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW.
REQ-017 frame_done  out  1  one-cycle pulse at each frame wrap.

Function
REQ-018 slot_cnt counts 0..REFRESH_DIV-1 and wraps; at terminal, digit_idx advances 0,1,..,NUM_DIGITS-1,0.
REQ-019 On slot_cnt terminal with digit_idx = NUM_DIGITS-1: snapshot registers load digits_bcd, dp_mask, blink_mask, blank_lz; frame_done pulses that same cycle.
REQ-020 All displayed content SHALL come from the snapshot only; mid-frame input changes SHALL not appear until the next frame.
REQ-021 blink_cnt counts 0..BLINK_DIV-1; at terminal blink_phase toggles.
REQ-022 Active-high segment codes: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex, bit6=g).
REQ-023 Nibble values A..F SHALL display a dash (g only, 40 hex).
REQ-024 Leading-zero blanking (blank_lz=1): scanning from digit NUM_DIGITS-1 down, zero digits are blanked until the first nonzero digit; digit 0 is never LZ-blanked; dash digits count as nonzero.
REQ-025 Digit blanked (segments and dp dark) when blink_mask[k]=1 and blink_phase=1.
REQ-026 During slot_cnt < DEAD_CYCLES, an SHALL be all inactive.
REQ-027 enable=0 forces an, seg, dp inactive.
REQ-028 seg, dp, an SHALL be registered, reflecting the previous cycle's digit_idx, slot_cnt, blink_phase and snapshot (1-cycle latency).
REQ-029 Exactly one anode active whenever outputs are not forced dark.

Reset
REQ-030 reset SHALL clear slot_cnt, digit_idx, blink_cnt, blink_phase and snapshot to 0, and frame_done to 0.
REQ-031 During reset and the following cycle, an, seg, dp SHALL be inactive-level.
REQ-032 reset asserted mid-slot or mid-frame SHALL abandon the frame; scanning restarts at digit 0, slot_cnt 0.

Structure
REQ-033 Shared package seg_pkg holds the segment-code constants, the dash code and the {g..a} bit-order definition.
REQ-034 One sub-module seg_bcd_decode (combinational nibble-to-active-high-segments, dash for A..F); polarity inversion occurs only in seg_scan_driver.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, BLINK_DIV=32, both polarities active-low)
REQ-035 Reset, digits_bcd=16'h1234, enable=1 -> frame_done after 16 cycles; next frame an cycles 1110,1101,1011,0111 (each 3 of 4 cycles, 1111 in dead cycle), seg = ~06? no: digit0 seg=7'b0011001 ("4"), digit3 seg=7'b1111001 ("1").
REQ-036 digits_bcd=16'h0007, blank_lz=1 -> digits 3..1 dark, digit 0 shows "7"; blank_lz=0 -> digits 3..1 show "0".
REQ-037 digits_bcd changed 16'h1234->16'h5678 mid-frame -> current frame still 1234; 5678 from first slot after next frame_done.
REQ-038 blink_mask=4'b0011 -> digits 1,0 dark for 32 cycles, lit for 32 cycles alternately; digits 3,2 always lit.
REQ-039 digits_bcd nibble 4'hB, dp_mask[2]=1 -> dash (seg=7'b0111111) on that digit, dp=0 only on digit 2 slot.
REQ-040 reset asserted during digit 2 slot -> next cycle outputs dark, then scan restarts at digit 0 with snapshot zero.
